mdu_ctrl: RTL



---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute-stage <-> multiply/divide unit handshake and HI/LO readout.
// master = pipeline side, slave = MDU side.
interface mdu_ctrl_if;
   logic        req;
   logic [5:0]  funct;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req, funct, rs, rt,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  req, funct, rs, rt,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MIPS multiply/divide sequencer owning HI/LO.
// Iterative 32-step shift-add multiplier and restoring divider on operand
// magnitudes, followed by one FIX cycle that applies sign correction.
// Optional build macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// combinational multiply and skip the RUN phase (divide unchanged).
module mdu_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   mdu_ctrl_if.slave  bus
);

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] opb;      // multiplicand or divisor magnitude
   logic [63:0] acc;      // mul: {partial, multiplier}; div: {rem, quotient}
   logic        is_div;
   logic        rsgn;     // product/quotient negate
   logic        rmsgn;    // remainder takes dividend sign
   logic        dz;       // divide by zero: quotient forced to all ones
   logic [31:0] hi_q, lo_q;
   logic        done_q;
   logic        busy_c;

   // request decode
   logic        accept, f_mul, f_div, f_sgn, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   always_comb begin
      accept = bus.req && (state == IDLE);
      f_mul  = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
      f_div  = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
      f_sgn  = (bus.funct == F_MULT) || (bus.funct == F_DIV);
      a_neg  = f_sgn && bus.rs[31];
      b_neg  = f_sgn && bus.rt[31];
      a_mag  = a_neg ? (32'd0 - bus.rs) : bus.rs;
      b_mag  = b_neg ? (32'd0 - bus.rt) : bus.rt;
   end

   // one iteration of each engine
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [32:0] div_shl;
   logic [33:0] div_diff;
   logic [63:0] div_nxt;

   always_comb begin
      mul_sum  = acc[0] ? ({1'b0, acc[63:32]} + {1'b0, opb}) : {1'b0, acc[63:32]};
      mul_nxt  = {mul_sum, acc[31:1]};
      div_shl  = {acc[63:32], acc[31]};
      div_diff = {1'b0, div_shl} - {2'b00, opb};
      if (!div_diff[33])
         div_nxt = {div_diff[31:0], acc[30:0], 1'b1};
      else
         div_nxt = {div_shl[31:0], acc[30:0], 1'b0};
   end

   // sign correction applied in FIX
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      prod_fix = rsgn ? (64'd0 - acc) : acc;
      quo_fix  = (rsgn && !dz) ? (32'd0 - acc[31:0]) : acc[31:0];
      rem_fix  = rmsgn ? (32'd0 - acc[63:32]) : acc[63:32];
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && f_div)
               state_nxt = RUN;
            else if (accept && f_mul) begin
`ifdef MDU_FAST_MUL_EN
               state_nxt = FIX;
`else
               state_nxt = RUN;
`endif
            end
         end
         RUN:     if (cnt == 5'd0) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      busy_c    = (state != IDLE);
      bus.busy  = busy_c;
      bus.stall = bus.req && busy_c;
      bus.done  = done_q;
      bus.hi    = hi_q;
      bus.lo    = lo_q;
   end

   // operand latch, iteration and HI/LO writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= 5'd0;
         opb    <= 32'd0;
         acc    <= 64'd0;
         is_div <= 1'b0;
         rsgn   <= 1'b0;
         rmsgn  <= 1'b0;
         dz     <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (accept && (f_mul || f_div)) begin
                  cnt    <= 5'd31;
                  is_div <= f_div;
                  rsgn   <= a_neg ^ b_neg;
                  rmsgn  <= f_div && a_neg;
                  dz     <= f_div && (bus.rt == 32'd0);
                  opb    <= f_div ? b_mag : a_mag;
                  if (f_div)
                     acc <= {32'd0, a_mag};
                  else begin
`ifdef MDU_FAST_MUL_EN
                     acc <= {32'd0, a_mag} * {32'd0, b_mag};
`else
                     acc <= {32'd0, b_mag};
`endif
                  end
               end
               if (accept && (bus.funct == F_MTHI)) hi_q <= bus.rs;
               if (accept && (bus.funct == F_MTLO)) lo_q <= bus.rs;
            end
            RUN: begin
               cnt <= cnt - 5'd1;
               acc <= is_div ? div_nxt : mul_nxt;
            end
            FIX: begin
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
